// File: rtl/sdram_sched_pkg.sv
// Shared types and helpers for the SDRAM frame scheduler.
// Contents: scheduler state enum, grant enum, column width, bank count,
//    next_bank() which picks the one bank in 0..N_BANKS-1 that is neither argument.
package sdram_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_e;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } grant_e;

   localparam int COL_W   = 9;
   localparam int N_BANKS = 3;

   // Lowest-numbered bank in 0..N_BANKS-1 that differs from both a and b.
   // Bank 3 can never be returned.
   function automatic logic [1:0] next_bank(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      r = 2'd0;
      for (int i = N_BANKS - 1; i >= 0; i--) begin
         if (2'(i) != a && 2'(i) != b) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sched_bank_rot.sv
// Triple-buffer bank rotation: tracks write bank, display bank and newest complete frame.
// Latency: bank changes are visible the cycle after the event strobe.
// Backpressure: none; events are strobes qualified by the scheduler (idle only).
// Ports: clk_i/rst_n_i (sync active-low), cam_evt_i/vga_evt_i frame events,
//    wr_full_i (current write frame complete), wr_bank_o, rd_bank_o.
module sched_bank_rot
   import sdram_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cam_evt_i,
   input  logic       vga_evt_i,
   input  logic       wr_full_i,
   output logic [1:0] wr_bank_o,
   output logic [1:0] rd_bank_o
);

   logic [1:0] wr_bank_q, wr_bank_d;
   logic [1:0] rd_bank_q, rd_bank_d;
   logic [1:0] newest_q,  newest_d;

   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      newest_d  = newest_q;
      // Camera first: a completed frame becomes newest and writing moves to the
      // bank neither displayed nor newest. An incomplete frame is simply rewritten.
      if (cam_evt_i && wr_full_i) begin
         newest_d  = wr_bank_q;
         wr_bank_d = next_bank(rd_bank_q, wr_bank_q);
      end
      // VGA sees the newest value including a same-cycle camera update.
      if (vga_evt_i) rd_bank_d = newest_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_bank_q <= 2'd0;
         rd_bank_q <= 2'd2;
         newest_q  <= 2'd2;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         newest_q  <= newest_d;
      end
   end

   assign wr_bank_o = wr_bank_q;
   assign rd_bank_o = rd_bank_q;

endmodule

// File: rtl/sdram_frame_sched.sv
// Shares one SDRAM burst channel between camera writes and VGA reads, triple-buffered.
// Latency: grant decided in idle, sd_req_o asserted next cycle; >=1 idle cycle between bursts.
// Backpressure: request held with stable sd_wr_o/sd_addr_o until sd_ack_i; frame events deferred.
// Ports: clk_i, rst_n_i (sync active-low), cam/vga_frame_start_i pulses, wr/rd_fifo_used_i levels,
//    sd_req_o/sd_wr_o/sd_addr_o/sd_ack_i burst channel, wr/rd_fifo_clear_o pulses,
//    wr_bank_o/rd_bank_o, wr_frame_done_o. Macro FRAME_SCHED_STATS_EN adds
//    wr_rows_last_o, rd_rows_last_o, rd_underrun_o.
module sdram_frame_sched
   import sdram_sched_pkg::*;
#(
   parameter int unsigned FRAME_ROWS   = 750,
   parameter int unsigned WR_HIGH_MARK = 512,
   parameter int unsigned RD_LOW_MARK  = 512,
   parameter int unsigned RD_URGENT    = 128
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cam_frame_start_i,
   input  logic        vga_frame_start_i,
   input  logic [10:0] wr_fifo_used_i,
   input  logic [10:0] rd_fifo_used_i,
   output logic        sd_req_o,
   output logic        sd_wr_o,
   output logic [23:0] sd_addr_o,
   input  logic        sd_ack_i,
   output logic        wr_fifo_clear_o,
   output logic        rd_fifo_clear_o,
   output logic [1:0]  wr_bank_o,
   output logic [1:0]  rd_bank_o,
`ifdef FRAME_SCHED_STATS_EN
   output logic [12:0] wr_rows_last_o,
   output logic [12:0] rd_rows_last_o,
   output logic        rd_underrun_o,
`endif
   output logic        wr_frame_done_o
);

   localparam logic [12:0] FRAME_ROWS_C = 13'(FRAME_ROWS);
   localparam logic [10:0] WR_HIGH_C    = 11'(WR_HIGH_MARK);
   localparam logic [10:0] RD_LOW_C     = 11'(RD_LOW_MARK);
   localparam logic [10:0] RD_URGENT_C  = 11'(RD_URGENT);

   state_e      state_q, state_d;
   grant_e      last_q, last_d;
   logic [12:0] wr_row_q, wr_row_d;
   logic [12:0] rd_row_q, rd_row_d;
   logic [23:0] addr_q, addr_d;
   logic        wr_clr_q, wr_clr_d;
   logic        rd_clr_q, rd_clr_d;
   logic        cam_pend_q, cam_pend_d;
   logic        vga_pend_q, vga_pend_d;

   logic idle, cam_evt, vga_evt, wr_ok, rd_ok, rd_urgent, wr_full;

   assign idle      = (state_q == S_IDLE);
   assign cam_evt   = idle && (cam_frame_start_i || cam_pend_q);
   assign vga_evt   = idle && (vga_frame_start_i || vga_pend_q);
   assign wr_full   = (wr_row_q == FRAME_ROWS_C);
   assign wr_ok     = (wr_fifo_used_i >= WR_HIGH_C) && (wr_row_q < FRAME_ROWS_C);
   assign rd_ok     = (rd_fifo_used_i <= RD_LOW_C) && (rd_row_q < FRAME_ROWS_C);
   assign rd_urgent = (rd_fifo_used_i < RD_URGENT_C);

   sched_bank_rot u_rot (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .cam_evt_i (cam_evt),
      .vga_evt_i (vga_evt),
      .wr_full_i (wr_full),
      .wr_bank_o (wr_bank_o),
      .rd_bank_o (rd_bank_o)
   );

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      wr_row_d   = wr_row_q;
      rd_row_d   = rd_row_q;
      addr_d     = addr_q;
      wr_clr_d   = 1'b0;
      rd_clr_d   = 1'b0;
      cam_pend_d = cam_pend_q;
      vga_pend_d = vga_pend_q;

      case (state_q)
         S_IDLE: begin
            cam_pend_d = 1'b0;
            vga_pend_d = 1'b0;
            if (cam_evt) begin
               wr_row_d = 13'd0;
               wr_clr_d = 1'b1;
            end
            if (vga_evt) begin
               rd_row_d = 13'd0;
               rd_clr_d = 1'b1;
            end
            // A serviced frame event takes the whole idle cycle; rows were just reset.
            if (!cam_evt && !vga_evt) begin
               if (wr_ok && (!rd_ok || (!rd_urgent && last_q == RD))) begin
                  state_d = S_WR;
                  last_d  = WR;
                  addr_d  = {wr_bank_o, wr_row_q, {COL_W{1'b0}}};
               end else if (rd_ok) begin
                  state_d = S_RD;
                  last_d  = RD;
                  addr_d  = {rd_bank_o, rd_row_q, {COL_W{1'b0}}};
               end
            end
         end
         S_WR, S_RD: begin
            // Outstanding bursts are never aborted; remember events for the next idle cycle.
            cam_pend_d = cam_pend_q | cam_frame_start_i;
            vga_pend_d = vga_pend_q | vga_frame_start_i;
            if (sd_ack_i) begin
               state_d = S_IDLE;
               if (state_q == S_WR) begin
                  if (wr_row_q != FRAME_ROWS_C) wr_row_d = wr_row_q + 13'd1;
               end else begin
                  if (rd_row_q != FRAME_ROWS_C) rd_row_d = rd_row_q + 13'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         last_q     <= RD;
         wr_row_q   <= 13'd0;
         rd_row_q   <= 13'd0;
         addr_q     <= 24'd0;
         wr_clr_q   <= 1'b0;
         rd_clr_q   <= 1'b0;
         cam_pend_q <= 1'b0;
         vga_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         wr_row_q   <= wr_row_d;
         rd_row_q   <= rd_row_d;
         addr_q     <= addr_d;
         wr_clr_q   <= wr_clr_d;
         rd_clr_q   <= rd_clr_d;
         cam_pend_q <= cam_pend_d;
         vga_pend_q <= vga_pend_d;
      end
   end

   assign sd_req_o        = (state_q != S_IDLE);
   assign sd_wr_o         = (state_q == S_WR);
   assign sd_addr_o       = addr_q;
   assign wr_fifo_clear_o = wr_clr_q;
   assign rd_fifo_clear_o = rd_clr_q;
   assign wr_frame_done_o = wr_full;

`ifdef FRAME_SCHED_STATS_EN
   logic [12:0] wr_rows_last_q, rd_rows_last_q;
   logic        rd_underrun_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_rows_last_q <= 13'd0;
         rd_rows_last_q <= 13'd0;
         rd_underrun_q  <= 1'b0;
      end else begin
         if (cam_evt) wr_rows_last_q <= wr_row_q;
         if (vga_evt) rd_rows_last_q <= rd_row_q;
         // Empty FIFO mid-frame means the display starved; sticky for software.
         if (rd_fifo_used_i == 11'd0 && rd_row_q != 13'd0 && rd_row_q < FRAME_ROWS_C)
            rd_underrun_q <= 1'b1;
      end
   end

   assign wr_rows_last_o = wr_rows_last_q;
   assign rd_rows_last_o = rd_rows_last_q;
   assign rd_underrun_o  = rd_underrun_q;
`endif

endmodule

// File: tb/tb_sdram_frame_sched.sv
module tb_sdram_frame_sched;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        cam_frame_start_i;
   logic        vga_frame_start_i;
   logic [10:0] wr_fifo_used_i;
   logic [10:0] rd_fifo_used_i;
   logic        sd_req_o;
   logic        sd_wr_o;
   logic [23:0] sd_addr_o;
   logic        sd_ack_i;
   logic        wr_fifo_clear_o;
   logic        rd_fifo_clear_o;
   logic [1:0]  wr_bank_o;
   logic [1:0]  rd_bank_o;
   logic        wr_frame_done_o;
`ifdef FRAME_SCHED_STATS_EN
   logic [12:0] wr_rows_last_o;
   logic [12:0] rd_rows_last_o;
   logic        rd_underrun_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   sdram_frame_sched dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .cam_frame_start_i (cam_frame_start_i),
      .vga_frame_start_i (vga_frame_start_i),
      .wr_fifo_used_i    (wr_fifo_used_i),
      .rd_fifo_used_i    (rd_fifo_used_i),
      .sd_req_o          (sd_req_o),
      .sd_wr_o           (sd_wr_o),
      .sd_addr_o         (sd_addr_o),
      .sd_ack_i          (sd_ack_i),
      .wr_fifo_clear_o   (wr_fifo_clear_o),
      .rd_fifo_clear_o   (rd_fifo_clear_o),
      .wr_bank_o         (wr_bank_o),
      .rd_bank_o         (rd_bank_o),
`ifdef FRAME_SCHED_STATS_EN
      .wr_rows_last_o    (wr_rows_last_o),
      .rd_rows_last_o    (rd_rows_last_o),
      .rd_underrun_o     (rd_underrun_o),
`endif
      .wr_frame_done_o   (wr_frame_done_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Waits (bounded) for a request, records it, holds it 'hold' cycles, then acks.
   task automatic serve_burst(input int hold, output bit to, output bit wr,
                              output logic [23:0] a0, output logic [23:0] a1);
      int n;
      n  = 0;
      to = 1'b0;
      while (!sd_req_o && n < 20) begin
         step();
         n++;
      end
      if (!sd_req_o) begin
         to = 1'b1; wr = 1'b0; a0 = 24'd0; a1 = 24'd0;
         return;
      end
      wr = sd_wr_o;
      a0 = sd_addr_o;
      repeat (hold) step();
      a1 = sd_addr_o;
      sd_ack_i = 1'b1;
      step();
      sd_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; cam_frame_start_i = 1'b0; vga_frame_start_i = 1'b0;
      wr_fifo_used_i = 11'd0; rd_fifo_used_i = 11'd1000; sd_ack_i = 1'b0;
      repeat (3) step();
      n_checks++; if (sd_req_o !== 1'b0) $display("FAIL reset_req got %0h want 0", sd_req_o); else n_pass++;
      n_checks++; if (sd_wr_o !== 1'b0) $display("FAIL reset_wr got %0h want 0", sd_wr_o); else n_pass++;
      n_checks++; if (sd_addr_o !== 24'h0) $display("FAIL reset_addr got %h want 000000", sd_addr_o); else n_pass++;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL reset_wr_bank got %0d want 0", wr_bank_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 2'd2) $display("FAIL reset_rd_bank got %0d want 2", rd_bank_o); else n_pass++;
      n_checks++; if ({wr_fifo_clear_o, rd_fifo_clear_o} !== 2'b00) $display("FAIL reset_clears got %b want 00", {wr_fifo_clear_o, rd_fifo_clear_o}); else n_pass++;
      n_checks++; if (wr_frame_done_o !== 1'b0) $display("FAIL reset_done got %0h want 0", wr_frame_done_o); else n_pass++;
      rst_n_i = 1'b1;
      step();
   endtask

   task automatic test_first_write();
      bit to, wr;
      logic [23:0] a0, a1;
      // ack while idle must be ignored (row stays 0)
      sd_ack_i = 1'b1; step(); sd_ack_i = 1'b0; step();
      n_checks++; if (sd_req_o !== 1'b0) $display("FAIL idle_no_req got %0h want 0", sd_req_o); else n_pass++;
      wr_fifo_used_i = 11'd600;
      serve_burst(2, to, wr, a0, a1);
      n_checks++; if (to || wr !== 1'b1) $display("FAIL first_wr got to=%0d wr=%0d want to=0 wr=1", to, wr); else n_pass++;
      n_checks++; if (a0 !== 24'h000000 || a1 !== 24'h000000) $display("FAIL first_addr got %h/%h want 000000", a0, a1); else n_pass++;
      n_checks++; if (sd_req_o !== 1'b0) $display("FAIL gap_after_ack got %0h want 0", sd_req_o); else n_pass++;
      serve_burst(0, to, wr, a0, a1);
      n_checks++; if (to || wr !== 1'b1 || a0 !== 24'h000200) $display("FAIL second_addr got to=%0d wr=%0d addr=%h want 0 1 000200", to, wr, a0); else n_pass++;
   endtask

   task automatic test_arbitration();
      bit to, wr;
      logic [23:0] a0, a1;
      bit          exp_w [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [23:0] exp_a [5] = '{24'h800000, 24'h000400, 24'h800200, 24'h800400, 24'h800600};
      rd_fifo_used_i = 11'd300;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) rd_fifo_used_i = 11'd100;
         serve_burst(0, to, wr, a0, a1);
         n_checks++;
         if (to || wr !== exp_w[i] || a0 !== exp_a[i])
            $display("FAIL arb_%0d got to=%0d wr=%0d addr=%h want wr=%0d addr=%h", i, to, wr, a0, exp_w[i], exp_a[i]);
         else n_pass++;
      end
   endtask

   task automatic test_full_frame();
      bit to, wr;
      logic [23:0] a0, a1;
      int errs;
      errs = 0;
      rd_fifo_used_i = 11'd1000;
      for (int i = 0; i < 747; i++) begin
         serve_burst(0, to, wr, a0, a1);
         if (to || !wr) errs++;
      end
      n_checks++; if (errs != 0 || a0 !== 24'h05DA00) $display("FAIL frame_writes got errs=%0d last=%h want 0 05da00", errs, a0); else n_pass++;
      n_checks++; if (wr_frame_done_o !== 1'b1) $display("FAIL frame_done got %0h want 1", wr_frame_done_o); else n_pass++;
      repeat (3) step();
      n_checks++; if (sd_req_o !== 1'b0) $display("FAIL row_saturate got req=%0h want 0", sd_req_o); else n_pass++;
      cam_frame_start_i = 1'b1; step(); cam_frame_start_i = 1'b0;
      n_checks++; if (wr_bank_o !== 2'd1 || rd_bank_o !== 2'd2) $display("FAIL cam_rotate got wr=%0d rd=%0d want 1 2", wr_bank_o, rd_bank_o); else n_pass++;
      n_checks++; if (wr_fifo_clear_o !== 1'b1 || sd_req_o !== 1'b0 || wr_frame_done_o !== 1'b0) $display("FAIL cam_evt_cycle got clr=%0h req=%0h done=%0h want 1 0 0", wr_fifo_clear_o, sd_req_o, wr_frame_done_o); else n_pass++;
      step();
      n_checks++; if (wr_fifo_clear_o !== 1'b0 || sd_req_o !== 1'b1 || sd_addr_o !== 24'h400000) $display("FAIL cam_after got clr=%0h req=%0h addr=%h want 0 1 400000", wr_fifo_clear_o, sd_req_o, sd_addr_o); else n_pass++;
      sd_ack_i = 1'b1; step(); sd_ack_i = 1'b0;
      wr_fifo_used_i = 11'd0;
      vga_frame_start_i = 1'b1; step(); vga_frame_start_i = 1'b0;
      n_checks++; if (rd_bank_o !== 2'd0 || rd_fifo_clear_o !== 1'b1) $display("FAIL vga_swap got rd=%0d clr=%0h want 0 1", rd_bank_o, rd_fifo_clear_o); else n_pass++;
      step();
      n_checks++; if (rd_fifo_clear_o !== 1'b0) $display("FAIL vga_clr_pulse got %0h want 0", rd_fifo_clear_o); else n_pass++;
   endtask

   task automatic test_partial_frame();
      bit to, wr;
      logic [23:0] a0, a1;
      int errs;
      errs = 0;
      wr_fifo_used_i = 11'd600;
      for (int i = 0; i < 399; i++) begin
         serve_burst(0, to, wr, a0, a1);
         if (to || !wr) errs++;
      end
      n_checks++; if (errs != 0 || a0 !== 24'h431E00) $display("FAIL partial_writes got errs=%0d last=%h want 0 431e00", errs, a0); else n_pass++;
      wr_fifo_used_i = 11'd0;
      cam_frame_start_i = 1'b1; step(); cam_frame_start_i = 1'b0;
      n_checks++; if (wr_bank_o !== 2'd1 || wr_fifo_clear_o !== 1'b1) $display("FAIL partial_keep got wr=%0d clr=%0h want 1 1", wr_bank_o, wr_fifo_clear_o); else n_pass++;
      wr_fifo_used_i = 11'd600;
      serve_burst(0, to, wr, a0, a1);
      n_checks++; if (to || a0 !== 24'h400000) $display("FAIL partial_row_reset got to=%0d addr=%h want 0 400000", to, a0); else n_pass++;
      wr_fifo_used_i = 11'd0;
      vga_frame_start_i = 1'b1; step(); vga_frame_start_i = 1'b0;
      n_checks++; if (rd_bank_o !== 2'd0) $display("FAIL partial_newest got rd=%0d want 0", rd_bank_o); else n_pass++;
   endtask

   task automatic test_simultaneous();
      bit to, wr;
      logic [23:0] a0, a1;
      int errs;
      errs = 0;
      wr_fifo_used_i = 11'd600;
      for (int i = 0; i < 749; i++) begin
         serve_burst(0, to, wr, a0, a1);
         if (to || !wr) errs++;
      end
      n_checks++; if (errs != 0 || wr_frame_done_o !== 1'b1) $display("FAIL sim_fill got errs=%0d done=%0h want 0 1", errs, wr_frame_done_o); else n_pass++;
      wr_fifo_used_i = 11'd0;
      cam_frame_start_i = 1'b1; vga_frame_start_i = 1'b1; step();
      cam_frame_start_i = 1'b0; vga_frame_start_i = 1'b0;
      n_checks++; if (rd_bank_o !== 2'd1 || wr_bank_o !== 2'd2) $display("FAIL sim_banks got rd=%0d wr=%0d want 1 2", rd_bank_o, wr_bank_o); else n_pass++;
      n_checks++; if ({wr_fifo_clear_o, rd_fifo_clear_o} !== 2'b11) $display("FAIL sim_clears got %b want 11", {wr_fifo_clear_o, rd_fifo_clear_o}); else n_pass++;
   endtask

   task automatic test_event_during_req();
      int n;
      n = 0;
      wr_fifo_used_i = 11'd600; rd_fifo_used_i = 11'd1000;
      while (!sd_req_o && n < 20) begin step(); n++; end
      n_checks++; if (sd_req_o !== 1'b1 || sd_addr_o !== 24'h800000) $display("FAIL busy_req got req=%0h addr=%h want 1 800000", sd_req_o, sd_addr_o); else n_pass++;
      cam_frame_start_i = 1'b1; step(); cam_frame_start_i = 1'b0;
      n_checks++; if (sd_req_o !== 1'b1 || wr_fifo_clear_o !== 1'b0) $display("FAIL busy_hold got req=%0h clr=%0h want 1 0", sd_req_o, wr_fifo_clear_o); else n_pass++;
      step();
      sd_ack_i = 1'b1; step(); sd_ack_i = 1'b0;
      n_checks++; if (sd_req_o !== 1'b0 || wr_fifo_clear_o !== 1'b0) $display("FAIL busy_ack got req=%0h clr=%0h want 0 0", sd_req_o, wr_fifo_clear_o); else n_pass++;
      step();
      n_checks++; if (wr_fifo_clear_o !== 1'b1 || sd_req_o !== 1'b0) $display("FAIL pend_service got clr=%0h req=%0h want 1 0", wr_fifo_clear_o, sd_req_o); else n_pass++;
      step();
      n_checks++; if (sd_req_o !== 1'b1 || sd_addr_o !== 24'h800000 || wr_bank_o !== 2'd2) $display("FAIL pend_regrant got req=%0h addr=%h wr=%0d want 1 800000 2", sd_req_o, sd_addr_o, wr_bank_o); else n_pass++;
      rst_n_i = 1'b0; step();
      n_checks++; if (sd_req_o !== 1'b0 || wr_bank_o !== 2'd0 || rd_bank_o !== 2'd2) $display("FAIL midreq_reset got req=%0h wr=%0d rd=%0d want 0 0 2", sd_req_o, wr_bank_o, rd_bank_o); else n_pass++;
      rst_n_i = 1'b1; step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d checks", n_checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_write();
      test_arbitration();
      test_full_frame();
      test_partial_frame();
      test_simultaneous();
      test_event_during_req();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
